// File: rtl/text_buffer_writer_if.sv
// Character handshake between the CPU/IO producer and text_buffer_writer.
// The master offers a code with in_valid; the slave accepts it when in_ready is high.
interface text_buffer_writer_if;
  logic [7:0] in_char;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_char,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_char,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/text_buffer_writer.sv
// Owns the 64x11 VGA character buffer: writes codes at a hardware cursor, handles control codes,
// and runs multi-cycle clear/scroll sweeps. Optional macro TEXT_SCROLL_EN enables scrolling at the last row.
module text_buffer_writer #(
  parameter int         COLS  = 64,
  parameter int         ROWS  = 11,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic                 clk,
  input  logic                 rst,
  text_buffer_writer_if.slave  bus,
  output logic [7:0]           text [COLS*ROWS],
  output logic [5:0]           cursor_col,
  output logic [3:0]           cursor_row,
  output logic                 busy
);

  localparam int         CELLS     = COLS * ROWS;
  localparam logic [9:0] LAST_IDX  = 10'(CELLS - 1);
  localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
  localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);

  localparam logic [7:0] CODE_BS = 8'h08;
  localparam logic [7:0] CODE_LF = 8'h0A;
  localparam logic [7:0] CODE_FF = 8'h0C;
  localparam logic [7:0] CODE_CR = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR
`ifdef TEXT_SCROLL_EN
    , SCROLL
`endif
  } state_t;

  state_t      state_q;
  logic [7:0]  text_q [CELLS];
  logic [5:0]  cursorCol_q;
  logic [3:0]  cursorRow_q;
  logic [9:0]  sweepIdx_q;
  logic        busy_q;

  logic        accept;
  logic        printable;
  logic        lineAdvance;
  logic [9:0]  curIdx;

  assign bus.in_ready = (state_q == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign printable    = (bus.in_char >= 8'h20) && (bus.in_char <= 8'h7E);
  assign curIdx       = 10'(cursorRow_q) * 10'(COLS) + 10'(cursorCol_q);

  // Line advance happens on newline, or when a printable wraps off the last column
  assign lineAdvance  = accept &&
                        ((bus.in_char == CODE_LF) || (printable && (cursorCol_q == LAST_COL)));

`ifdef TEXT_SCROLL_EN
  localparam logic [9:0] SCROLL_LIMIT = 10'(CELLS - COLS);
  logic [9:0] scrollSrc;
  assign scrollSrc = (sweepIdx_q < SCROLL_LIMIT) ? sweepIdx_q + 10'(COLS) : sweepIdx_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) text_q[i] <= BLANK;
      state_q     <= IDLE;
      cursorCol_q <= '0;
      cursorRow_q <= '0;
      sweepIdx_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (printable) begin
              text_q[curIdx] <= bus.in_char;
              cursorCol_q    <= (cursorCol_q == LAST_COL) ? 6'd0 : cursorCol_q + 6'd1;
            end else begin
              case (bus.in_char)
                CODE_LF, CODE_CR: cursorCol_q <= '0;
                // Stepping back one cell from (r,0) lands on (r-1,63), i.e. curIdx-1 in both cases
                CODE_BS: begin
                  if (cursorCol_q != 6'd0) begin
                    cursorCol_q        <= cursorCol_q - 6'd1;
                    text_q[curIdx - 1] <= BLANK;
                  end else if (cursorRow_q != 4'd0) begin
                    cursorRow_q        <= cursorRow_q - 4'd1;
                    cursorCol_q        <= LAST_COL;
                    text_q[curIdx - 1] <= BLANK;
                  end
                end
                CODE_FF: begin
                  state_q    <= CLEAR;
                  busy_q     <= 1'b1;
                  sweepIdx_q <= '0;
                end
                default: ;
              endcase
            end

            if (lineAdvance) begin
              if (cursorRow_q != LAST_ROW) begin
                cursorRow_q <= cursorRow_q + 4'd1;
              end else begin
`ifdef TEXT_SCROLL_EN
                state_q    <= SCROLL;
                busy_q     <= 1'b1;
                sweepIdx_q <= '0;
`else
                cursorRow_q <= '0;
`endif
              end
            end
          end
        end

        CLEAR: begin
          text_q[sweepIdx_q] <= BLANK;
          if (sweepIdx_q == LAST_IDX) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            cursorCol_q <= '0;
            cursorRow_q <= '0;
          end else begin
            sweepIdx_q <= sweepIdx_q + 10'd1;
          end
        end

`ifdef TEXT_SCROLL_EN
        // Rows move up one at a time in index order, so each source row is read before it is overwritten
        SCROLL: begin
          text_q[sweepIdx_q] <= (sweepIdx_q < SCROLL_LIMIT) ? text_q[scrollSrc] : BLANK;
          if (sweepIdx_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            sweepIdx_q <= sweepIdx_q + 10'd1;
          end
        end
`endif

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign text       = text_q;
  assign cursor_col = cursorCol_q;
  assign cursor_row = cursorRow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_text_buffer_writer.sv
// Directed self-checking bench for text_buffer_writer (default build or with TEXT_SCROLL_EN defined).
module tb_text_buffer_writer;

  logic       clk;
  logic       rst;
  logic [7:0] text [704];
  logic [5:0] cursor_col;
  logic [3:0] cursor_row;
  logic       busy;

  int testCount;
  int failCount;

  text_buffer_writer_if bus ();

  text_buffer_writer dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .text       (text),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one code, wait (bounded) for acceptance, and return #1 after the accepting edge
  task automatic applyStimulus(input logic [7:0] code);
    int waited;
    waited = 0;
    bus.in_char  = code;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 2000) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.in_ready) checkOutput("readyTimeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic sendRepeat(input logic [7:0] code, input int n);
    for (int k = 0; k < n; k++) applyStimulus(code);
  endtask

  task automatic doReset();
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic countNonBlank(output int n);
    n = 0;
    for (int i = 0; i < 704; i++) if (text[i] !== 8'h20) n++;
  endtask

  // Counts cycles busy stays high (sampled #1 after each edge) and cycles where in_ready was also high
  task automatic measureSweep(output int cycles, output int readyHigh);
    cycles = 0;
    readyHigh = 0;
    while (busy && cycles < 2000) begin
      cycles++;
      if (bus.in_ready) readyHigh++;
      @(posedge clk); #1;
    end
  endtask

  int n;
  int cycles;
  int readyHigh;

  initial begin
    testCount = 0;
    failCount = 0;
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    rst = 1'b1;
    #12;
    checkOutput("readyInReset", 32'(bus.in_ready), 32'd0);
    checkOutput("busyInReset", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    countNonBlank(n);
    checkOutput("resetBlank", n, 0);
    checkOutput("resetCol", 32'(cursor_col), 0);
    checkOutput("resetRow", 32'(cursor_row), 0);
    checkOutput("resetReady", 32'(bus.in_ready), 1);
    checkOutput("resetBusy", 32'(busy), 0);

    applyStimulus(8'h48);
    checkOutput("hText0", 32'(text[0]), 32'h48);
    checkOutput("hCol", 32'(cursor_col), 1);
    applyStimulus(8'h69);
    checkOutput("iText1", 32'(text[1]), 32'h69);
    checkOutput("iCol", 32'(cursor_col), 2);
    checkOutput("iRow", 32'(cursor_row), 0);

    doReset();
    applyStimulus(8'h08);
    checkOutput("bsOriginCol", 32'(cursor_col), 0);
    checkOutput("bsOriginRow", 32'(cursor_row), 0);
    sendRepeat(8'h41, 64);
    checkOutput("wrapRow", 32'(cursor_row), 1);
    checkOutput("wrapCol", 32'(cursor_col), 0);
    checkOutput("wrapText63", 32'(text[63]), 32'h41);
    applyStimulus(8'h08);
    checkOutput("bs1Row", 32'(cursor_row), 0);
    checkOutput("bs1Col", 32'(cursor_col), 63);
    checkOutput("bs1Text63", 32'(text[63]), 32'h20);
    applyStimulus(8'h08);
    checkOutput("bs2Col", 32'(cursor_col), 62);
    checkOutput("bs2Text62", 32'(text[62]), 32'h20);
    checkOutput("bs2Text61", 32'(text[61]), 32'h41);
    applyStimulus(8'h7F);
    applyStimulus(8'h00);
    applyStimulus(8'h1B);
    checkOutput("ignoredCol", 32'(cursor_col), 62);
    checkOutput("ignoredText62", 32'(text[62]), 32'h20);
    applyStimulus(8'h0D);
    checkOutput("crCol", 32'(cursor_col), 0);
    checkOutput("crRow", 32'(cursor_row), 0);

    doReset();
    sendRepeat(8'h58, 64);
    sendRepeat(8'h0A, 9);
    sendRepeat(8'h59, 5);
    checkOutput("preClearRow", 32'(cursor_row), 10);
    checkOutput("preClearCol", 32'(cursor_col), 5);
    checkOutput("preClearText0", 32'(text[0]), 32'h58);
    applyStimulus(8'h0C);
    bus.in_char  = 8'h51;
    bus.in_valid = 1'b1;
    measureSweep(cycles, readyHigh);
    bus.in_valid = 1'b0;
    checkOutput("clearCycles", cycles, 704);
    checkOutput("clearReadyLow", readyHigh, 0);
    countNonBlank(n);
    checkOutput("clearBlank", n, 0);
    checkOutput("clearCol", 32'(cursor_col), 0);
    checkOutput("clearRow", 32'(cursor_row), 0);

`ifdef TEXT_SCROLL_EN
    doReset();
    applyStimulus(8'h0A);
    sendRepeat(8'h42, 64);
    sendRepeat(8'h0A, 8);
    sendRepeat(8'h63, 3);
    checkOutput("preScrollRow", 32'(cursor_row), 10);
    checkOutput("preScrollCol", 32'(cursor_col), 3);
    applyStimulus(8'h0A);
    measureSweep(cycles, readyHigh);
    checkOutput("scrollCycles", cycles, 704);
    checkOutput("scrollText0", 32'(text[0]), 32'h42);
    checkOutput("scrollText63", 32'(text[63]), 32'h42);
    checkOutput("scrollText64", 32'(text[64]), 32'h20);
    checkOutput("scrollText576", 32'(text[576]), 32'h63);
    checkOutput("scrollText640", 32'(text[640]), 32'h20);
    checkOutput("scrollText703", 32'(text[703]), 32'h20);
    checkOutput("scrollRow", 32'(cursor_row), 10);
    checkOutput("scrollCol", 32'(cursor_col), 0);
`else
    doReset();
    sendRepeat(8'h0A, 10);
    sendRepeat(8'h61, 63);
    checkOutput("preWrapRow", 32'(cursor_row), 10);
    checkOutput("preWrapCol", 32'(cursor_col), 63);
    applyStimulus(8'h5A);
    checkOutput("wrapBusy", 32'(busy), 0);
    checkOutput("wrapText703", 32'(text[703]), 32'h5A);
    checkOutput("wrapText640", 32'(text[640]), 32'h61);
    checkOutput("wrapHomeRow", 32'(cursor_row), 0);
    checkOutput("wrapHomeCol", 32'(cursor_col), 0);
    applyStimulus(8'h5B);
    checkOutput("overwriteText0", 32'(text[0]), 32'h5B);
`endif

    doReset();
    sendRepeat(8'h4D, 5);
    applyStimulus(8'h0C);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("midClearBusy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("abortBusy", 32'(busy), 0);
    checkOutput("abortReady", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    countNonBlank(n);
    checkOutput("abortBlank", n, 0);
    checkOutput("abortIdleReady", 32'(bus.in_ready), 1);
    checkOutput("abortCol", 32'(cursor_col), 0);
    applyStimulus(8'h4B);
    checkOutput("afterAbortText0", 32'(text[0]), 32'h4B);
    checkOutput("afterAbortCol", 32'(cursor_col), 1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
